// File: rtl/result_uart_framer_pkg.sv
// Shared constants and types for the result UART framer.
// Packet field offsets, opcode codes and FSM state encoding.
package result_uart_framer_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int FRAME_BYTES = 15;
  localparam int PKT_BITS = 98;

  localparam int A_MSB   = 97;
  localparam int B_MSB   = 65;
  localparam int OP_MSB  = 33;
  localparam int RES_MSB = 31;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/result_uart_framer.sv
// Serialises a 98-bit result packet into a 15-byte UART frame:
// sync, A, B, opcode, result (MSB first), then XOR checksum.
module result_uart_framer
  import result_uart_framer_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF,
  parameter int         PKT_WIDTH  = 98,
  parameter int         COUNT_BITS = 16
) (
  input  logic                  clk_100MHz,
  input  logic                  reset,
  input  logic [PKT_WIDTH-1:0]  pkt_data,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  input  logic                  tx_full,
  output logic                  write_uart,
  output logic [7:0]            write_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic [COUNT_BITS-1:0] frame_count
);

  if (PKT_WIDTH != PKT_BITS) begin : g_width_check
    $error("result_uart_framer: PKT_WIDTH must be 98");
  end

  state_t                  state_q;
  state_t                  state_d;
  logic [PKT_WIDTH-1:0]    shadow_q;
  logic [3:0]              idx_q;
  logic [7:0]              csum_q;
  logic                    done_q;
  logic [COUNT_BITS-1:0]   count_q;

  logic [31:0] fa;
  logic [31:0] fb;
  logic [1:0]  fop;
  logic [31:0] fres;
  logic [7:0]  byte_sel;
  logic        in_send;
  logic        accept;
  logic        last;

  assign fa   = shadow_q[A_MSB -: 32];
  assign fb   = shadow_q[B_MSB -: 32];
  assign fop  = shadow_q[OP_MSB -: 2];
  assign fres = shadow_q[RES_MSB -: 32];

  assign in_send     = (state_q == SEND);
  assign pkt_ready   = (state_q == IDLE);
  assign busy        = in_send;
  assign accept      = pkt_valid && pkt_ready;
  assign write_uart  = in_send && !tx_full;
  assign last        = write_uart && (idx_q == LAST_IDX);
  assign write_data  = in_send ? byte_sel : 8'h00;
  assign frame_done  = done_q;
  assign frame_count = count_q;

  // Select the frame byte at the current index from the shadow copy.
  always_comb begin
    byte_sel = 8'h00;
    unique case (idx_q)
      4'd0:    byte_sel = SYNC_BYTE;
      4'd1:    byte_sel = fa[31:24];
      4'd2:    byte_sel = fa[23:16];
      4'd3:    byte_sel = fa[15:8];
      4'd4:    byte_sel = fa[7:0];
      4'd5:    byte_sel = fb[31:24];
      4'd6:    byte_sel = fb[23:16];
      4'd7:    byte_sel = fb[15:8];
      4'd8:    byte_sel = fb[7:0];
      4'd9:    byte_sel = {6'b0, fop};
      4'd10:   byte_sel = fres[31:24];
      4'd11:   byte_sel = fres[23:16];
      4'd12:   byte_sel = fres[15:8];
      4'd13:   byte_sel = fres[7:0];
      4'd14:   byte_sel = csum_q;
      default: byte_sel = 8'h00;
    endcase
  end

  // Next state: leave IDLE on accept, return after the checksum write.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SEND;
      SEND:    if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, capture, byte index, running checksum and frame counter.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      csum_q   <= '0;
      done_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= last;
      if (accept) begin
        shadow_q <= pkt_data;
        idx_q    <= '0;
        csum_q   <= '0;
      end
      if (write_uart) begin
        if (last) begin
          idx_q   <= '0;
          count_q <= count_q + 1'b1;
        end else begin
          idx_q <= idx_q + 4'd1;
        end
        if (idx_q != 4'd0 && idx_q != LAST_IDX) begin
          csum_q <= csum_q ^ byte_sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_result_uart_framer.sv
// Directed self-checking bench for result_uart_framer.
// A narrow-counter second instance exercises frame_count wrap.
module tb_result_uart_framer;

  logic        clk;
  logic        reset;
  logic [97:0] pkt_data;
  logic        pkt_valid;
  logic        pkt_ready;
  logic        tx_full;
  logic        write_uart;
  logic [7:0]  write_data;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_count;

  logic        w_pkt_ready;
  logic        w_write_uart;
  logic [7:0]  w_write_data;
  logic        w_busy;
  logic        w_frame_done;
  logic [1:0]  w_frame_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp [15];
  logic [7:0] got [15];
  int nw, first_cyc, last_cyc, done_cyc;
  int stall_bad, ready_bad, wdone;

  localparam logic [97:0] P1 =
    {32'h3F800000, 32'h40000000, 2'b00, 32'h40400000};
  localparam logic [97:0] P2 =
    {32'hC0000000, 32'h3F800000, 2'b01, 32'hC0400000};
  localparam logic [97:0] P3 =
    {32'h12345678, 32'h9ABCDEF0, 2'b10, 32'h0F0F0F0F};
  localparam logic [97:0] P4 =
    {32'h00000001, 32'h00000002, 2'b11, 32'h00000004};

  result_uart_framer dut (
    .clk_100MHz  (clk),
    .reset       (reset),
    .pkt_data    (pkt_data),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (pkt_ready),
    .tx_full     (tx_full),
    .write_uart  (write_uart),
    .write_data  (write_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  result_uart_framer #(.COUNT_BITS(2)) u_wrap (
    .clk_100MHz  (clk),
    .reset       (reset),
    .pkt_data    (pkt_data),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (w_pkt_ready),
    .tx_full     (tx_full),
    .write_uart  (w_write_uart),
    .write_data  (w_write_data),
    .busy        (w_busy),
    .frame_done  (w_frame_done),
    .frame_count (w_frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic void set_exp(input logic [97:0] p);
    logic [7:0] x;
    exp[0]  = 8'hA5;
    exp[1]  = p[97:90];
    exp[2]  = p[89:82];
    exp[3]  = p[81:74];
    exp[4]  = p[73:66];
    exp[5]  = p[65:58];
    exp[6]  = p[57:50];
    exp[7]  = p[49:42];
    exp[8]  = p[41:34];
    exp[9]  = {6'b0, p[33:32]};
    exp[10] = p[31:24];
    exp[11] = p[23:16];
    exp[12] = p[15:8];
    exp[13] = p[7:0];
    x = 8'h00;
    for (int i = 1; i < 14; i++) x = x ^ exp[i];
    exp[14] = x;
  endfunction

  task automatic offer(input logic [97:0] p);
    int n;
    @(negedge clk);
    pkt_valid = 1'b1;
    pkt_data  = p;
    n = 0;
    #1;
    while (!pkt_ready && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (!pkt_ready) begin
      errors++;
      $display("FAIL offer_timeout: pkt_ready=%b required 1", pkt_ready);
    end
  endtask

  // mode 0: no stall, 1: stall s_len cycles at byte s_start, 2: toggle
  task automatic collect(input int mode, input int s_start,
                         input int s_len, input bit hold,
                         input logic [97:0] nxt);
    int stalled;
    stalled = 0;
    nw = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
    stall_bad = 0; ready_bad = 0; wdone = 0;
    for (int i = 0; i < 15; i++) got[i] = 8'hxx;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 0) begin
        if (hold) pkt_data = nxt;
        else pkt_valid = 1'b0;
      end
      tx_full = 1'b0;
      if (mode == 1 && nw == s_start && stalled < s_len) begin
        tx_full = 1'b1;
        stalled++;
      end
      if (mode == 2) tx_full = (c % 2 == 0);
      #1;
      if (w_frame_done) wdone++;
      if (frame_done) begin
        done_cyc = c;
        break;
      end
      if (pkt_ready) ready_bad++;
      if (tx_full) begin
        if (write_uart) stall_bad++;
        if (nw < 15 && write_data !== exp[nw]) stall_bad++;
      end
      if (write_uart) begin
        if (nw < 15) got[nw] = write_data;
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        nw++;
      end
    end
    tx_full = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; pkt_valid = 1'b0; tx_full = 1'b0; pkt_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({pkt_ready, busy, frame_done, write_uart} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags: rdy/busy/done/wr=%b%b%b%b required 1000",
               pkt_ready, busy, frame_done, write_uart);
    end
    checks++;
    if (frame_count !== 16'h0000 || write_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_vals: count=%h data=%h required 0000 00",
               frame_count, write_data);
    end
  endtask

  task automatic test_basic;
    exp = '{8'hA5, 8'h3F, 8'h80, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h40, 8'h40, 8'h00, 8'h00, 8'hFF};
    offer(P1);
    collect(0, 0, 0, 1'b0, '0);
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL basic_byte%0d: got %h required %h", i, got[i], exp[i]);
      end
    end
    checks++;
    if (nw != 15 || first_cyc != 0 || last_cyc != 14 || done_cyc != 15) begin
      errors++;
      $display("FAIL basic_timing: n=%0d first=%0d last=%0d done=%0d required 15 0 14 15",
               nw, first_cyc, last_cyc, done_cyc);
    end
    checks++;
    if (frame_count !== 16'd1) begin
      errors++;
      $display("FAIL basic_count: got %0d required 1", frame_count);
    end
    @(negedge clk);
    #1;
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_width: frame_done=%b required 0", frame_done);
    end
  endtask

  task automatic test_stall;
    exp = '{8'hA5, 8'h3F, 8'h80, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h40, 8'h40, 8'h00, 8'h00, 8'hFF};
    offer(P1);
    collect(1, 3, 5, 1'b0, '0);
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL stall_byte%0d: got %h required %h", i, got[i], exp[i]);
      end
    end
    checks++;
    if (stall_bad != 0) begin
      errors++;
      $display("FAIL stall_hold: %0d bad stall cycles, required 0", stall_bad);
    end
    checks++;
    if (nw != 15 || last_cyc != 19 || frame_count !== 16'd2) begin
      errors++;
      $display("FAIL stall_timing: n=%0d last=%0d count=%0d required 15 19 2",
               nw, last_cyc, frame_count);
    end
  endtask

  task automatic test_back_to_back;
    set_exp(P1);
    offer(P1);
    collect(0, 0, 0, 1'b1, P2);
    checks++;
    if (ready_bad != 0 || nw != 15) begin
      errors++;
      $display("FAIL b2b_ready: ready_high=%0d n=%0d required 0 15",
               ready_bad, nw);
    end
    set_exp(P2);
    collect(0, 0, 0, 1'b0, '0);
    checks++;
    if (first_cyc != 0 || nw != 15) begin
      errors++;
      $display("FAIL b2b_gap: first=%0d n=%0d required 0 15", first_cyc, nw);
    end
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL b2b_byte%0d: got %h required %h", i, got[i], exp[i]);
      end
    end
    checks++;
    if (got[14] !== 8'hFE || frame_count !== 16'd4) begin
      errors++;
      $display("FAIL b2b_csum: csum=%h count=%0d required FE 4",
               got[14], frame_count);
    end
  endtask

  task automatic test_reset_midframe;
    set_exp(P1);
    offer(P1);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      pkt_valid = 1'b0;
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({write_uart, pkt_ready, busy} !== 3'b010 || frame_count !== 16'd0) begin
      errors++;
      $display("FAIL midreset: wr/rdy/busy=%b%b%b count=%0d required 010 0",
               write_uart, pkt_ready, busy, frame_count);
    end
    set_exp(P3);
    offer(P3);
    collect(0, 0, 0, 1'b0, '0);
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL midreset_byte%0d: got %h required %h",
                 i, got[i], exp[i]);
      end
    end
    checks++;
    if (frame_count !== 16'd1 || nw != 15) begin
      errors++;
      $display("FAIL midreset_count: count=%0d n=%0d required 1 15",
               frame_count, nw);
    end
  endtask

  task automatic test_op11;
    set_exp(P4);
    offer(P4);
    collect(0, 0, 0, 1'b0, '0);
    checks++;
    if (got[9] !== 8'h03 || got[14] !== 8'h04) begin
      errors++;
      $display("FAIL op11: byte9=%h csum=%h required 03 04", got[9], got[14]);
    end
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL op11_byte%0d: got %h required %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_wrap_toggle;
    set_exp(P2);
    offer(P2);
    collect(0, 0, 0, 1'b0, '0);
    checks++;
    if (w_frame_count !== 2'd3) begin
      errors++;
      $display("FAIL wrap_pre: count=%0d required 3", w_frame_count);
    end
    set_exp(P3);
    offer(P3);
    collect(2, 0, 0, 1'b0, '0);
    checks++;
    if (w_frame_count !== 2'd0 || wdone != 1) begin
      errors++;
      $display("FAIL wrap: count=%0d pulses=%0d required 0 1",
               w_frame_count, wdone);
    end
    checks++;
    if (nw != 15 || stall_bad != 0 || last_cyc != 29) begin
      errors++;
      $display("FAIL toggle_timing: n=%0d bad=%0d last=%0d required 15 0 29",
               nw, stall_bad, last_cyc);
    end
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL toggle_byte%0d: got %h required %h",
                 i, got[i], exp[i]);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (w_frame_done !== 1'b0 || frame_count !== 16'd4) begin
      errors++;
      $display("FAIL wrap_after: done=%b count=%0d required 0 4",
               w_frame_done, frame_count);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_back_to_back;
    test_reset_midframe;
    test_op11;
    test_wrap_toggle;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
